// File: rtl/thermostat_pkg.sv
// Shared state encoding, default thresholds and a threshold sanity check
// for the multi-zone thermostat.
package thermostat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAT = 2'd1,
        ST_COOL = 2'd2
    } zone_state_t;

    localparam int unsigned DEF_TEMP_W    = 5;
    localparam int unsigned DEF_N_ZONES   = 4;
    localparam int unsigned DEF_HEAT_ON   = 18;
    localparam int unsigned DEF_TARGET    = 20;
    localparam int unsigned DEF_COOL_ON   = 22;
    localparam int unsigned DEF_MIN_DWELL = 4;

    function automatic bit thresholds_ok(input int unsigned temp_w,
                                         input int unsigned heat_on,
                                         input int unsigned target,
                                         input int unsigned cool_on);
        longint unsigned temp_max;
        temp_max = (longint'(1) << temp_w) - 1;
        return (heat_on < target) && (target < cool_on) &&
               (longint'(cool_on) <= temp_max);
    endfunction

endpackage

// File: rtl/thermostat_zone.sv
// One thermostat channel: IDLE/HEATING/COOLING FSM with hysteresis,
// minimum-dwell timer, zone enable and a one-cycle state-change strobe.
module thermostat_zone
    import thermostat_pkg::*;
#(
    parameter int unsigned TEMP_W    = DEF_TEMP_W,
    parameter int unsigned HEAT_ON   = DEF_HEAT_ON,
    parameter int unsigned TARGET    = DEF_TARGET,
    parameter int unsigned COOL_ON   = DEF_COOL_ON,
    parameter int unsigned MIN_DWELL = DEF_MIN_DWELL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [TEMP_W-1:0] temp_i,
    output logic              heating_o,
    output logic              cooling_o,
    output logic              changed_o
);

    if (!thresholds_ok(TEMP_W, HEAT_ON, TARGET, COOL_ON)) begin : g_bad_thresholds
        $fatal(1, "thermostat_zone: need HEAT_ON < TARGET < COOL_ON <= 2^TEMP_W-1");
    end

    localparam int unsigned DW = (MIN_DWELL == 0) ? 1 : $clog2(MIN_DWELL + 1);

    localparam logic [TEMP_W-1:0] HEAT_ON_T = HEAT_ON[TEMP_W-1:0];
    localparam logic [TEMP_W-1:0] TARGET_T  = TARGET[TEMP_W-1:0];
    localparam logic [TEMP_W-1:0] COOL_ON_T = COOL_ON[TEMP_W-1:0];
    localparam logic [DW-1:0]     DWELL_MAX = MIN_DWELL[DW-1:0];
    localparam logic [DW-1:0]     DWELL_ONE = DW'(1);

    zone_state_t   state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          changed_q, changed_d;
    logic          dwell_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            dwell_q   <= DWELL_MAX;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dwell_q   <= dwell_d;
            changed_q <= changed_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dwell_d   = dwell_q;
        changed_d = 1'b0;
        dwell_ok  = (dwell_q == DWELL_MAX);

        // HEAT and COOL only ever exit to IDLE, so a reversal always pays both dwells
        case (state_q)
            ST_IDLE: begin
                if (dwell_ok) begin
                    if (temp_i <= HEAT_ON_T)      state_d = ST_HEAT;
                    else if (temp_i >= COOL_ON_T) state_d = ST_COOL;
                end
            end
            ST_HEAT: if (dwell_ok && temp_i >= TARGET_T) state_d = ST_IDLE;
            ST_COOL: if (dwell_ok && temp_i <= TARGET_T) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (!en_i) state_d = ST_IDLE;

        if (state_d != state_q) begin
            dwell_d   = '0;
            changed_d = 1'b1;
        end else if (!dwell_ok) begin
            dwell_d = dwell_q + DWELL_ONE;
        end
    end

    assign heating_o = (state_q == ST_HEAT);
    assign cooling_o = (state_q == ST_COOL);
    assign changed_o = changed_q;

endmodule

// File: rtl/thermostat_multizone.sv
// N_ZONES independent thermostat channels with aggregate heating/cooling
// status flags.
module thermostat_multizone
    import thermostat_pkg::*;
#(
    parameter int unsigned TEMP_W    = DEF_TEMP_W,
    parameter int unsigned N_ZONES   = DEF_N_ZONES,
    parameter int unsigned HEAT_ON   = DEF_HEAT_ON,
    parameter int unsigned TARGET    = DEF_TARGET,
    parameter int unsigned COOL_ON   = DEF_COOL_ON,
    parameter int unsigned MIN_DWELL = DEF_MIN_DWELL
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_ZONES-1:0]        zone_en,
    input  logic [N_ZONES*TEMP_W-1:0] temperature,
    output logic [N_ZONES-1:0]        heating,
    output logic [N_ZONES-1:0]        cooling,
    output logic [N_ZONES-1:0]        changed,
    output logic                      any_heating,
    output logic                      any_cooling
);

    for (genvar i = 0; i < N_ZONES; i++) begin : g_zone
        thermostat_zone #(
            .TEMP_W    (TEMP_W),
            .HEAT_ON   (HEAT_ON),
            .TARGET    (TARGET),
            .COOL_ON   (COOL_ON),
            .MIN_DWELL (MIN_DWELL)
        ) u_zone (
            .clk       (clk),
            .rst_n     (rst_n),
            .en_i      (zone_en[i]),
            .temp_i    (temperature[i*TEMP_W +: TEMP_W]),
            .heating_o (heating[i]),
            .cooling_o (cooling[i]),
            .changed_o (changed[i])
        );
    end

    assign any_heating = |heating;
    assign any_cooling = |cooling;

endmodule
